// File: rtl/mem_stage.sv
// Memory pipeline stage: ALU pass-through plus load/store transactions on a 64-bit req/ack bus.
// Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        valid_i,
  input  logic [63:0] alu_res_i,
  input  logic [63:0] store_data_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  input  logic        write_back_i,
  input  logic        load_flag_i,
  input  logic        mem_en_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_wstrb_o,
  input  logic        mem_ack_i,
  input  logic [63:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_en_o,
  output logic [4:0]  wb_rd_o,
  output logic [63:0] wb_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state_reg;
  logic [63:0] addr_reg;
  logic [4:0]  rd_reg;
  logic [2:0]  funct3_reg;
  logic        load_reg;
  logic        wb_flag_reg;
  logic        mem_req_reg;
  logic        mem_we_reg;
  logic [63:0] mem_wdata_reg;
  logic [7:0]  mem_wstrb_reg;
  logic        wb_valid_reg;
  logic        wb_en_reg;
  logic [4:0]  wb_rd_reg;
  logic [63:0] wb_data_reg;
  logic        misalign_reg;
  logic        bus_err_reg;

  logic [7:0]  size_mask;
  logic [2:0]  align_mask;
  logic        misaligned;
  logic        issue;
  logic        timeout_hit;
  logic [63:0] lane_data;
  logic [63:0] ld_data_next;
  logic [7:0]  wstrb_next;
  logic [63:0] wdata_next;

  // Byte-enable pattern of the access size, before lane shifting
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_size_mask
      assign size_mask[gi] = (gi < (1 << funct3_i[1:0]));
    end
  endgenerate

  assign align_mask = {size_mask[4], size_mask[2], size_mask[1]};
  assign misaligned = |(alu_res_i[2:0] & align_mask);
  assign issue      = valid_i && mem_en_i && !misaligned;
  assign wstrb_next = load_flag_i ? 8'h00 : (size_mask << alu_res_i[2:0]);
  assign wdata_next = store_data_i << {alu_res_i[2:0], 3'b000};
  assign lane_data  = mem_rdata_i >> {addr_reg[2:0], 3'b000};

  always_comb begin
    ld_data_next = lane_data;
    case (funct3_reg)
      3'b000:  ld_data_next = {{56{lane_data[7]}},  lane_data[7:0]};
      3'b001:  ld_data_next = {{48{lane_data[15]}}, lane_data[15:0]};
      3'b010:  ld_data_next = {{32{lane_data[31]}}, lane_data[31:0]};
      3'b100:  ld_data_next = {56'd0, lane_data[7:0]};
      3'b101:  ld_data_next = {48'd0, lane_data[15:0]};
      3'b110:  ld_data_next = {32'd0, lane_data[31:0]};
      default: ld_data_next = lane_data;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_reg;

  assign timeout_hit = !mem_ack_i && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err_o   = bus_err_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      wait_cnt_reg <= '0;
    end else if (!mem_ack_i) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end
`else
  // Never true: without the timeout the bus wait is unbounded
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign bus_err_o   = 1'b0;
`endif

  assign stall_o = (state_reg == IDLE) ? issue : (!mem_ack_i && !timeout_hit);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      rd_reg        <= '0;
      funct3_reg    <= '0;
      load_reg      <= 1'b0;
      wb_flag_reg   <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
      wb_valid_reg  <= 1'b0;
      wb_en_reg     <= 1'b0;
      wb_rd_reg     <= '0;
      wb_data_reg   <= '0;
      misalign_reg  <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      wb_valid_reg <= 1'b0;
      wb_en_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (valid_i && !mem_en_i) begin
            wb_valid_reg <= 1'b1;
            wb_en_reg    <= write_back_i;
            wb_rd_reg    <= rd_i;
            wb_data_reg  <= alu_res_i;
          end else if (valid_i && misaligned) begin
            wb_valid_reg <= 1'b1;
            wb_rd_reg    <= rd_i;
            wb_data_reg  <= '0;
            misalign_reg <= 1'b1;
          end else if (issue) begin
            state_reg     <= BUS;
            addr_reg      <= alu_res_i;
            rd_reg        <= rd_i;
            funct3_reg    <= funct3_i;
            load_reg      <= load_flag_i;
            wb_flag_reg   <= write_back_i;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= !load_flag_i;
            mem_wdata_reg <= wdata_next;
            mem_wstrb_reg <= wstrb_next;
          end
        end
        BUS: begin
          if (mem_ack_i) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_wstrb_reg <= '0;
            wb_valid_reg  <= 1'b1;
            wb_rd_reg     <= rd_reg;
            wb_en_reg     <= load_reg && wb_flag_reg;
            wb_data_reg   <= load_reg ? ld_data_next : 64'd0;
          end else if (timeout_hit) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_wstrb_reg <= '0;
            wb_valid_reg  <= 1'b1;
            wb_rd_reg     <= rd_reg;
            wb_data_reg   <= '0;
            bus_err_reg   <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = mem_req_reg;
  assign mem_we_o    = mem_we_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign mem_wstrb_o = mem_wstrb_reg;
  assign wb_valid_o  = wb_valid_reg;
  assign wb_en_o     = wb_en_reg;
  assign wb_rd_o     = wb_rd_reg;
  assign wb_data_o   = wb_data_reg;
  assign misalign_o  = misalign_reg;

endmodule
